// File: rtl/priority_n_reg_pkg.sv
// Shared definitions for the N-lane registered priority/XOR cell.
// Index-width helper and error-class bit positions on the monitor bus.
package priority_pkg;

    localparam int ERR_MULTI = 0;
    localparam int ERR_IN    = 1;
    localparam int ERR_EMPTY = 2;
    localparam int ERR_W     = 3;

    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/priority_n_reg_onehot_enc_n.sv
// Popcount class (zero/one/many) plus index encoder for N lanes.
// idx is forced to 0 unless exactly one lane is set.
module onehot_enc_n
    import priority_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     bits,
    output logic             zero,
    output logic             one,
    output logic             many,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] or_idx;

    // clearing the lowest set bit leaves something only if 2+ are set
    assign zero = ~|bits;
    assign many = |(bits & (bits - N'(1)));
    assign one  = ~zero & ~many;

    // OR of lane numbers is exact only for one-hot input
    always_comb begin
        or_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bits[i]) begin
                or_idx = or_idx | IDX_W'(i);
            end
        end
    end

    assign idx = one ? or_idx : '0;

endmodule

// File: rtl/priority_n_reg.sv
// Pipelined N-lane priority cell with error classes and sticky latch.
// Define PRIORITY_N_ERR_CNT_EN to add the saturating err_cnt port.
module priority_n_reg
    import priority_pkg::*;
#(
    parameter int N           = 4,
    parameter int IDX_W       = idx_w(N),
    parameter int PIPE_STAGES = 1,
    parameter int STRICT      = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_bits,
    input  logic [N-1:0]     in_err,
    input  logic             err_clr,
    output logic             out_valid,
    output logic             Y,
    output logic [IDX_W-1:0] idx,
    output logic             err,
    output logic             err_multi,
    output logic             err_in,
    output logic             err_empty,
    output logic             err_sticky
`ifdef PRIORITY_N_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef struct packed {
        logic             v;
        logic             y;
        logic [IDX_W-1:0] idx;
        logic [ERR_W-1:0] ec;
    } beat_t;

    logic             enc_zero;
    logic             enc_one;
    logic             enc_many;
    logic [IDX_W-1:0] enc_idx;
    beat_t            s1_d;
    beat_t            s1_q;
    beat_t            out_q;
    logic             beat_err;

    onehot_enc_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .bits (in_bits),
        .zero (enc_zero),
        .one  (enc_one),
        .many (enc_many),
        .idx  (enc_idx)
    );

    // classify the incoming beat; idle cycles load an all-zero bundle
    always_comb begin
        s1_d = '0;
        if (in_valid) begin
            s1_d.v             = 1'b1;
            s1_d.y             = enc_one;
            s1_d.idx           = enc_idx;
            s1_d.ec[ERR_MULTI] = enc_many;
            s1_d.ec[ERR_IN]    = |in_err;
            s1_d.ec[ERR_EMPTY] = (STRICT != 0) && enc_zero;
        end
    end

    // first pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    if (PIPE_STAGES == 2) begin : g_s2
        beat_t s2_q;

        // optional second stage is a straight copy for timing
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_q <= '0;
            end else begin
                s2_q <= s1_q;
            end
        end

        assign out_q = s2_q;
    end else begin : g_s1
        assign out_q = s1_q;
    end

    assign out_valid = out_q.v;
    assign Y         = out_q.y;
    assign idx       = out_q.idx;
    assign err_multi = out_q.ec[ERR_MULTI];
    assign err_in    = out_q.ec[ERR_IN];
    assign err_empty = (STRICT != 0) && out_q.ec[ERR_EMPTY];
    assign err       = err_multi | err_in | err_empty;
    assign beat_err  = out_q.v & err;

    // sticky latch: an erroring beat beats a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (beat_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef PRIORITY_N_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // saturating count; clear plus erroring beat restarts at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (beat_err) begin
            if (err_clr) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

endmodule

// File: doc/priority_n_reg.md
Name: priority_n_reg

Overview:
- Parametrised, pipelined successor of the 2-input registered priority/XOR cell.
- Takes N digit-valid lines plus N per-digit error flags from the TPU residue-digit datapath.
- Each valid beat produces a registered "exactly one digit valid" flag and the encoded winning index.
- Error outputs are classified as multi-hot, input-propagated, or (optionally) empty, with a sticky error latch for the host-side error monitor.

Parameters:
- N, 4, number of digit-valid input lanes (2..32).
- IDX_W, $clog2(N) (minimum 1), width of encoded index output.
- PIPE_STAGES, 1, output latency in cycles (1 or 2); stage 2 is a plain register copy.
- STRICT, 0, when 1 an all-zero valid beat is flagged as an error (err_empty); when 0 it is benign.
- CNT_W, 8, error counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat qualifier.
- in_bits  in  N  digit-valid lines.
- in_err  in  N  per-lane upstream error flags.
- err_clr  in  1  synchronous clear of err_sticky (and err_cnt).
- out_valid  out  1  output beat qualifier, in_valid delayed PIPE_STAGES.
- Y  out  1  exactly one in_bits set.
- idx  out  IDX_W  index of the set lane when Y=1, else 0.
- err  out  1  OR of err_multi, err_in, err_empty.
- err_multi  out  1  two or more in_bits set.
- err_in  out  1  any in_err set.
- err_empty  out  1  STRICT=1 and in_bits all zero; tied 0 when STRICT=0.
- err_sticky  out  1  latched OR of err over all valid beats since reset/clear.
- err_cnt  out  CNT_W  count of erroring beats (present only with the optional feature).

Behaviour:
- Reset (rst_n low, asynchronous): every output and pipeline register is 0, including out_valid, err_sticky and err_cnt. Reset mid-pipeline discards in-flight beats; no beat emerges after release.
- Stage 1 on each clk: if in_valid=1, load Y = popcount(in_bits)==1, idx = encoded lane, err_multi = popcount>=2, err_in = |in_err, err_empty per STRICT; out_valid pipe gets 1.
- If in_valid=0, stage 1 loads all zeros (out_valid=0). in_bits and in_err are ignored when in_valid=0.
- Latency: PIPE_STAGES cycles from in_valid sample to out_valid. Throughput: one beat per cycle, no backpressure.
- idx is 0 whenever Y=0; multi-hot never yields a partial index.
- err_in is independent of Y: a one-hot beat with in_err set gives Y=1 and err=1.
- err_sticky sets on the cycle after any output beat with out_valid=1 and err=1. It clears on the cycle after err_clr=1.
- Simultaneous err_clr and an erroring output beat: set wins, err_sticky=1.
- err_clr with no error pending: err_sticky=0.

Optional Feature:
- Macro PRIORITY_N_ERR_CNT_EN.
- Defined: err_cnt port and counter exist. Counter increments by 1 on each output beat with out_valid=1 and err=1. It saturates at 2^CNT_W-1 with no wrap. err_clr sets it to 0.
- err_clr together with an erroring beat: counter becomes 1.
- Undefined: no counter logic and no err_cnt port; all other behaviour is identical.

Decomposition:
- Package priority_pkg: IDX width function (clog2 with minimum 1) and localparam error-class bit positions (MULTI=0, IN=1, EMPTY=2) for the monitor bus.
- One natural sub-module, onehot_enc_n: combinational popcount-class (zero/one/many) plus index encoder, parametrised by N. Reused by future wider priority cells.
- Pipeline, sticky latch and counter stay in priority_n_reg.

Test Plan:
- N=4, PIPE_STAGES=1: in_valid=1, in_bits=4'b0100, in_err=0 -> next cycle out_valid=1, Y=1, idx=2, err=0.
- in_bits=4'b0110, in_err=0 -> Y=0, idx=0, err_multi=1, err=1, err_sticky=1 the following cycle. A later clean beat leaves err_sticky=1 until err_clr.
- in_bits=4'b0001, in_err=4'b1000 -> Y=1, idx=0, err_in=1. With STRICT=1, in_bits=0 gives err_empty=1; with STRICT=0 it gives err=0.
- PIPE_STAGES=2, back-to-back beats 0001, 0010, 1000 -> outputs appear on cycles 2, 3, 4 with idx 0, 1, 3; no bubbles.
- PRIORITY_N_ERR_CNT_EN, CNT_W=2: 5 consecutive erroring beats -> err_cnt saturates at 3. err_clr coincident with an erroring beat -> err_cnt=1, err_sticky=1.
- Assert rst_n low mid-stream with 2 beats in flight -> all outputs 0 immediately. After release, out_valid stays 0 until a new in_valid beat.
